// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the HI/LO multiply/divide unit.
// No timing of its own.
// No flow control; constants and pure functions only.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [4:0]  ITER_LAST = 5'd31;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of a possibly-signed operand; 0x80000000 maps onto itself and
    // is then read as unsigned 2^31, which is what the iterations need.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: a shift-add (multiply) or restoring shift-subtract (divide) step.
// Purely combinational, zero latency.
// No flow control; the owning FSM decides when the result is captured.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        i_div,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_opb,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Multiply: add operand when the low bit of the multiplier is set, then shift the
    // 64-bit {hi,lo} right by one, pulling the carry in. Divide: shift remainder left
    // with the next dividend bit, subtract the divisor using a guard bit and keep the
    // difference only when it is non-negative.
    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opb} : 33'd0);
        w_shift = {i_hi, i_lo[31]};
        w_diff  = w_shift - {1'b0, i_opb};
        o_hi    = w_sum[32:1];
        o_lo    = {w_sum[0], i_lo[31:1]};
        if (i_div) begin
            if (!w_diff[32]) begin
                o_hi = w_diff[31:0];
                o_lo = {i_lo[30:0], 1'b1};
            end else begin
                o_hi = w_shift[31:0];
                o_lo = {i_lo[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers, with MTHI/MTLO write-through.
// Launch-to-result 33 edges (32 iterations + 1 sign-fix edge); done_o pulses the cycle after.
// No queuing: start_i and hilo_we_i are ignored while busy_o is high; the hazard unit must stall.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] RSdata_i,
    input  logic [WIDTH-1:0] RTdata_i,
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] hilo_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] HI_o,
    output logic [WIDTH-1:0] LO_o
);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dz;
    logic [31:0] r_rs;
    logic [31:0] r_opb;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic        w_idle;
    logic [31:0] w_nxt_hi;
    logic [31:0] w_nxt_lo;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_signed = ~op_i[0];
    assign w_idle   = (r_state == ST_IDLE);

    muldiv_step u_step (
        .i_div (r_is_div),
        .i_hi  (r_acc_hi),
        .i_lo  (r_acc_lo),
        .i_opb (r_opb),
        .o_hi  (w_nxt_hi),
        .o_lo  (w_nxt_lo)
    );

    // Sign correction applied on the FIX edge; divide-by-zero bypasses it entirely.
    always_comb begin
        w_prod   = r_neg_res ? (64'd0 - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = r_rs;
                w_res_lo = DIV0_LO;
            end else begin
                w_res_lo = r_neg_res ? (32'd0 - r_acc_lo) : r_acc_lo;
                w_res_hi = r_neg_rem ? (32'd0 - r_acc_hi) : r_acc_hi;
            end
        end
    end

    // FSM, iteration counter, operand latches and architectural HI/LO.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_rs      <= 32'd0;
            r_opb     <= 32'd0;
            r_acc_hi  <= 32'd0;
            r_acc_lo  <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (hilo_we_i[1]) r_hi <= hilo_data_i;
                    if (hilo_we_i[0]) r_lo <= hilo_data_i;
                    if (start_i) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= 5'd0;
                        r_is_div  <= op_i[1];
                        r_neg_res <= w_signed & (RSdata_i[31] ^ RTdata_i[31]);
                        r_neg_rem <= w_signed & RSdata_i[31];
                        r_dz      <= op_i[1] & (RTdata_i == 32'd0);
                        r_rs      <= RSdata_i;
                        r_opb     <= mag32(RTdata_i, w_signed);
                        r_acc_hi  <= 32'd0;
                        r_acc_lo  <= mag32(RSdata_i, w_signed);
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == ITER_LAST) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign done_o = r_done;
    assign HI_o   = (w_idle && hilo_we_i[1]) ? hilo_data_i : r_hi;
    assign LO_o   = (w_idle && hilo_we_i[0]) ? hilo_data_i : r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: scoreboard of expected {HI,LO} pushed at launch, popped at done_o.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait for done_o is bounded by a cycle budget.
module tb_hilo_muldiv;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] RSdata_i = 32'd0;
    logic [31:0] RTdata_i = 32'd0;
    logic [1:0]  hilo_we_i = 2'b00;
    logic [31:0] hilo_data_i = 32'd0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] HI_o;
    logic [31:0] LO_o;

    logic [63:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .RSdata_i    (RSdata_i),
        .RTdata_i    (RTdata_i),
        .hilo_we_i   (hilo_we_i),
        .hilo_data_i (hilo_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .HI_o        (HI_o),
        .LO_o        (LO_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model of the architectural result, {HI,LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic signed [63:0] sa, sb;
        logic signed [31:0] s_rs, s_rt, s_q, s_r;
        sa   = {{32{rs[31]}}, rs};
        sb   = {{32{rt[31]}}, rt};
        s_rs = rs;
        s_rt = rt;
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'd0, rs} * {32'd0, rt};
            OP_DIV: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                s_q = s_rs / s_rt;
                s_r = s_rs % s_rt;
                return {s_r, s_q};
            end
            default: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
        endcase
    endfunction

    // Drive a one-cycle start at the current falling edge; returns one cycle later.
    task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        start_i  = 1'b1;
        op_i     = op;
        RSdata_i = rs;
        RTdata_i = rt;
        @(negedge clk_i);
        start_i  = 1'b0;
        RSdata_i = 32'hA5A5_5A5A;
        RTdata_i = 32'h5A5A_A5A5;
    endtask

    // Wait (bounded) for done_o, count busy cycles on the way, pop and compare.
    task automatic wait_done(input string name, output int busy_cnt);
        logic [63:0] exp;
        bit          seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (done_o === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy_o === 1'b1) busy_cnt++;
            @(negedge clk_i);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: done_o not seen, busy cycles %0d", name, busy_cnt);
            return;
        end
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s done_o with empty scoreboard", name);
            return;
        end
        exp = sb_q.pop_front();
        n_vec++;
        if (HI_o !== exp[63:32]) begin
            n_err++;
            $display("FAIL %s HI got %h want %h", name, HI_o, exp[63:32]);
        end
        n_vec++;
        if (LO_o !== exp[31:0]) begin
            n_err++;
            $display("FAIL %s LO got %h want %h", name, LO_o, exp[31:0]);
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy in done cycle got %b want 0", name, busy_o);
        end
        last_hi = exp[63:32];
        last_lo = exp[31:0];
    endtask

    // Runs one op start to finish and checks done_o drops after a single cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [63:0] exp);
        int bc;
        sb_q.push_back(exp);
        launch(op, rs, rt);
        wait_done(name, bc);
        @(negedge clk_i);
        n_vec++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s done width got done_o=%b want 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_vec++;
        if ({busy_o, done_o, HI_o, LO_o} !== 66'd0) begin
            n_err++;
            $display("FAIL reset got busy=%b done=%b HI=%h LO=%h want all 0", busy_o, done_o, HI_o, LO_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_multu_timing();
        int bc;
        sb_q.push_back(64'hFFFF_FFFE_0000_0001);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", bc);
        n_vec++;
        if (bc != 33) begin
            n_err++;
            $display("FAIL multu_busy_cycles got %0d want 33", bc);
        end
        @(negedge clk_i);
        n_vec++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL multu_done_width got %b want 0", done_o);
        end
    endtask

    task automatic test_mult_div();
        run_op("mult_neg",   OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min",   OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("div_neg",    OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_small", OP_DIVU, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
    endtask

    task automatic test_div_zero();
        run_op("divu_zero", OP_DIVU, 32'd5,         32'd0, 64'h0000_0005_FFFF_FFFF);
        run_op("div_zero",  OP_DIV,  32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
    endtask

    task automatic test_busy_ignore();
        int bc;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        repeat (4) @(negedge clk_i);
        start_i     = 1'b1;
        op_i        = OP_MULTU;
        RSdata_i    = 32'd1;
        RTdata_i    = 32'd1;
        hilo_we_i   = 2'b01;
        hilo_data_i = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (LO_o !== last_lo) begin
            n_err++;
            $display("FAIL busy_mtlo_passthru LO got %h want %h", LO_o, last_lo);
        end
        @(negedge clk_i);
        start_i   = 1'b0;
        hilo_we_i = 2'b00;
        wait_done("busy_ignore", bc);
        @(negedge clk_i);
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_relaunch got busy=%b done=%b want 0/0", busy_o, done_o);
        end
    endtask

    task automatic test_reset_midop();
        bit stray = 0;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({busy_o, done_o, HI_o, LO_o} !== 66'd0) begin
            n_err++;
            $display("FAIL midop_reset got busy=%b done=%b HI=%h LO=%h want all 0", busy_o, done_o, HI_o, LO_o);
        end
        rst_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) stray = 1;
        end
        n_vec++;
        if (stray || HI_o !== 32'd0 || LO_o !== 32'd0) begin
            n_err++;
            $display("FAIL midop_no_done got stray=%b HI=%h LO=%h want 0/0/0", stray, HI_o, LO_o);
        end
        run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 64'd12);
    endtask

    task automatic test_mthi_mtlo();
        int bc;
        hilo_we_i   = 2'b10;
        hilo_data_i = 32'h0000_1234;
        #1;
        n_vec++;
        if (HI_o !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL mthi_writethru got %h want 00001234", HI_o);
        end
        @(negedge clk_i);
        hilo_we_i   = 2'b00;
        hilo_data_i = 32'h0;
        #1;
        n_vec++;
        if (HI_o !== 32'h0000_1234 || LO_o !== last_lo) begin
            n_err++;
            $display("FAIL mthi_held got HI=%h LO=%h want 00001234 %h", HI_o, LO_o, last_lo);
        end
        hilo_we_i   = 2'b01;
        hilo_data_i = 32'h0000_1234;
        sb_q.push_back(64'd4);
        #1;
        n_vec++;
        if (LO_o !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL mtlo_writethru got %h want 00001234", LO_o);
        end
        start_i  = 1'b1;
        op_i     = OP_MULTU;
        RSdata_i = 32'd2;
        RTdata_i = 32'd2;
        @(negedge clk_i);
        start_i   = 1'b0;
        hilo_we_i = 2'b00;
        #1;
        n_vec++;
        if (LO_o !== 32'h0000_1234 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL mtlo_start_same_cycle got LO=%h busy=%b want 00001234 1", LO_o, busy_o);
        end
        wait_done("mtlo_then_multu", bc);
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int          bc;
        logic [1:0]  op;
        logic [31:0] rs, rt;
        sb_q.push_back(model(OP_DIV, 32'd1000, 32'hFFFF_FFFD));
        launch(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
        for (int k = 0; k < 6; k++) begin
            wait_done("b2b", bc);
            op = 2'($urandom_range(0, 3));
            rs = $urandom;
            rt = (k == 2) ? 32'd0 : $urandom;
            if (k == 4) rt = 32'd1 + 32'($urandom_range(0, 300));
            sb_q.push_back(model(op, rs, rt));
            launch(op, rs, rt);
            n_vec++;
            if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_relaunch k=%0d got busy=%b done=%b want 1/0", k, busy_o, done_o);
            end
        end
        wait_done("b2b_last", bc);
        @(negedge clk_i);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_multu_timing();
        test_mult_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_midop();
        test_mthi_mtlo();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
